// File: rtl/hazard_stall_unit_pkg.sv
// hazard_pkg
//   Shared types and constants for the hazard/stall control slice:
//   memory-hold FSM state type, the x0 register index, the width of the
//   optional performance counters (HAZARD_PERF_EN), and a helper that
//   tests a destination register against both source fields.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } hold_state_e;

   localparam logic [4:0]  REG_X0     = 5'd0;
   localparam int unsigned PERF_CNT_W = 32;

   // x0 never carries a dependency; both source fields are always compared.
   function automatic logic rd_hits(input logic [4:0] rd,
                                    input logic [4:0] rs1,
                                    input logic [4:0] rs2);
      return (rd != REG_X0) && ((rd == rs1) || (rd == rs2));
   endfunction

endpackage

// File: rtl/hazard_stall_unit_mem_hold_fsm.sv
// mem_hold_fsm
//   Tracks an outstanding data-memory handshake and freezes the pipeline
//   while it is pending, with a watchdog that latches a sticky error.
//   Parameter TIMEOUT_CYCLES : max consecutive hold cycles (0 = no watchdog).
//   Ports:
//     i_clk, i_rst_n   clock, async active-low reset
//     i_dmem_req       MEM stage has an access pending
//     i_dmem_ready     memory completes the access this cycle
//     o_hold           freeze request (combinational)
//     o_err            registered sticky timeout flag
//   Macro HAZARD_PERF_EN adds a handshake protocol assertion.
module mem_hold_fsm
   import hazard_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_dmem_req,
   input  logic i_dmem_ready,
   output logic o_hold,
   output logic o_err
);

   localparam int unsigned   CW      = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT   = CW'(TIMEOUT_CYCLES);
   localparam bit            WDOG_EN = (TIMEOUT_CYCLES != 0);

   hold_state_e   r_state;
   hold_state_e   w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [CW-1:0] w_cnt_inc;
   logic          r_err;
   logic          w_wait;

   assign w_wait    = i_dmem_req & ~i_dmem_ready;
   assign w_cnt_inc = r_cnt + CW'(1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= RUN;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_err   <= (w_state_nxt == ERR);
      end
   end

   // The entry cycle already counts as one hold cycle, so RUN loads 1.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         RUN: begin
            w_cnt_nxt = '0;
            if (w_wait) begin
               w_cnt_nxt   = CW'(1);
               w_state_nxt = (WDOG_EN && (LIMIT == CW'(1))) ? ERR : MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            // Completion or a dropped request both end the wait.
            if (!w_wait) begin
               w_state_nxt = RUN;
               w_cnt_nxt   = '0;
            end else if (WDOG_EN) begin
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == LIMIT) w_state_nxt = ERR;
            end
         end
         ERR: w_state_nxt = ERR;
         default: begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign o_hold = (r_state == ERR) | w_wait;
   assign o_err  = r_err;

`ifdef HAZARD_PERF_EN
   a_req_held_until_ready: assert property (
      @(posedge i_clk) disable iff (!i_rst_n)
      (r_state == MEM_WAIT) |-> (i_dmem_req || i_dmem_ready));
`endif

endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Resolves hazards the forwarding path cannot: load-use stalls, operand
//   stalls for branches resolved in ID, taken-branch flushes, and a full
//   pipeline freeze while a data-memory access is outstanding.
//   Parameter TIMEOUT_CYCLES : memory-hold watchdog limit (0 disables).
//   Ports:
//     clk, rst_n                        clock, async active-low reset
//     IFID_RS1/RS2, IFID_Branch         ID-stage sources / branch-in-ID
//     BRANCH_TAKEN                      branch in ID resolved taken
//     IDEX_RD/MemRead/RegWrite          EX-stage destination info
//     EXMEM_RD/MemRead                  MEM-stage destination info
//     DMEM_REQ, DMEM_READY              data-memory handshake
//     PC_WRITE, IFID_WRITE, IFID_FLUSH, IDEX_BUBBLE, PIPE_HOLD  controls
//     MEM_TIMEOUT                       sticky watchdog error
//   Macro HAZARD_PERF_EN adds STALL_CNT / FLUSH_CNT (32-bit) outputs.
module hazard_stall_unit
   import hazard_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] IFID_RS1,
   input  logic [4:0] IFID_RS2,
   input  logic       IFID_Branch,
   input  logic       BRANCH_TAKEN,
   input  logic [4:0] IDEX_RD,
   input  logic       IDEX_MemRead,
   input  logic       IDEX_RegWrite,
   input  logic [4:0] EXMEM_RD,
   input  logic       EXMEM_MemRead,
   input  logic       DMEM_REQ,
   input  logic       DMEM_READY,
   output logic       PC_WRITE,
   output logic       IFID_WRITE,
   output logic       IFID_FLUSH,
   output logic       IDEX_BUBBLE,
   output logic       PIPE_HOLD,
   output logic       MEM_TIMEOUT
`ifdef HAZARD_PERF_EN
   ,
   output logic [PERF_CNT_W-1:0] STALL_CNT,
   output logic [PERF_CNT_W-1:0] FLUSH_CNT
`endif
);

   logic w_hit_ex;
   logic w_hit_mem;
   logic w_load_use;
   logic w_br_ex;
   logic w_br_mem;
   logic w_stall;
   logic w_hold;
   logic w_err;

   assign w_hit_ex   = rd_hits(IDEX_RD,  IFID_RS1, IFID_RS2);
   assign w_hit_mem  = rd_hits(EXMEM_RD, IFID_RS1, IFID_RS2);
   assign w_load_use = IDEX_MemRead & w_hit_ex;
   assign w_br_ex    = IFID_Branch & IDEX_RegWrite & w_hit_ex;
   assign w_br_mem   = IFID_Branch & EXMEM_MemRead & w_hit_mem;
   assign w_stall    = w_load_use | w_br_ex | w_br_mem;

   mem_hold_fsm #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_mem_hold_fsm (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_dmem_req   (DMEM_REQ),
      .i_dmem_ready (DMEM_READY),
      .o_hold       (w_hold),
      .o_err        (w_err)
   );

   // Reset is applied combinationally so the pipeline sees a bubble/no-advance
   // pattern for the whole time rst_n is low, not just after the next edge.
   always_comb begin
      PC_WRITE    = 1'b1;
      IFID_WRITE  = 1'b1;
      IFID_FLUSH  = 1'b0;
      IDEX_BUBBLE = 1'b0;
      PIPE_HOLD   = 1'b0;
      if (!rst_n) begin
         PC_WRITE    = 1'b0;
         IFID_WRITE  = 1'b0;
         IDEX_BUBBLE = 1'b1;
      end else if (w_hold) begin
         PIPE_HOLD  = 1'b1;
         PC_WRITE   = 1'b0;
         IFID_WRITE = 1'b0;
      end else if (w_stall) begin
         // Branch outcome is computed from stale operands here, so ignore it.
         PC_WRITE    = 1'b0;
         IFID_WRITE  = 1'b0;
         IDEX_BUBBLE = 1'b1;
      end else if (BRANCH_TAKEN) begin
         IFID_FLUSH = 1'b1;
      end
   end

   assign MEM_TIMEOUT = w_err;

`ifdef HAZARD_PERF_EN
   logic [PERF_CNT_W-1:0] r_stall_cnt;
   logic [PERF_CNT_W-1:0] r_flush_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (!PC_WRITE)  r_stall_cnt <= r_stall_cnt + PERF_CNT_W'(1);
         if (IFID_FLUSH) r_flush_cnt <= r_flush_cnt + PERF_CNT_W'(1);
      end
   end

   assign STALL_CNT = r_stall_cnt;
   assign FLUSH_CNT = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit
//   Directed and randomized stimulus for hazard_stall_unit with a
//   behavioural reference model. Output vector order used throughout:
//   {PC_WRITE, IFID_WRITE, IFID_FLUSH, IDEX_BUBBLE, PIPE_HOLD, MEM_TIMEOUT}.
//   Honours HAZARD_PERF_EN for the counter ports.
module tb_hazard_stall_unit;

   localparam int unsigned TMO = 16;

   typedef struct {
      logic [4:0] rs1, rs2, idex_rd, exmem_rd;
      logic       br, taken, idex_mr, idex_rw, exmem_mr, req, ready;
   } stim_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] IFID_RS1 = '0, IFID_RS2 = '0, IDEX_RD = '0, EXMEM_RD = '0;
   logic       IFID_Branch = 1'b0, BRANCH_TAKEN = 1'b0, IDEX_MemRead = 1'b0;
   logic       IDEX_RegWrite = 1'b0, EXMEM_MemRead = 1'b0;
   logic       DMEM_REQ = 1'b0, DMEM_READY = 1'b0;
   logic       PC_WRITE, IFID_WRITE, IFID_FLUSH, IDEX_BUBBLE, PIPE_HOLD, MEM_TIMEOUT;
`ifdef HAZARD_PERF_EN
   logic [31:0] STALL_CNT, FLUSH_CNT;
`endif

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   // reference model state
   int unsigned m_run   = 0;   // consecutive wait cycles seen so far
   bit          m_err   = 1'b0;
   longint unsigned m_stall = 0;
   longint unsigned m_flush = 0;

   always #5 clk = ~clk;

   hazard_stall_unit #(
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .IFID_RS1      (IFID_RS1),
      .IFID_RS2      (IFID_RS2),
      .IFID_Branch   (IFID_Branch),
      .BRANCH_TAKEN  (BRANCH_TAKEN),
      .IDEX_RD       (IDEX_RD),
      .IDEX_MemRead  (IDEX_MemRead),
      .IDEX_RegWrite (IDEX_RegWrite),
      .EXMEM_RD      (EXMEM_RD),
      .EXMEM_MemRead (EXMEM_MemRead),
      .DMEM_REQ      (DMEM_REQ),
      .DMEM_READY    (DMEM_READY),
      .PC_WRITE      (PC_WRITE),
      .IFID_WRITE    (IFID_WRITE),
      .IFID_FLUSH    (IFID_FLUSH),
      .IDEX_BUBBLE   (IDEX_BUBBLE),
      .PIPE_HOLD     (PIPE_HOLD),
      .MEM_TIMEOUT   (MEM_TIMEOUT)
`ifdef HAZARD_PERF_EN
      ,
      .STALL_CNT     (STALL_CNT),
      .FLUSH_CNT     (FLUSH_CNT)
`endif
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [5:0] dut_vec();
      return {PC_WRITE, IFID_WRITE, IFID_FLUSH, IDEX_BUBBLE, PIPE_HOLD, MEM_TIMEOUT};
   endfunction

   // Set of registers the ID instruction reads, excluding x0.
   function automatic bit reads(input stim_t s, input logic [4:0] rd);
      return (rd != 5'd0) && (rd == s.rs1 || rd == s.rs2);
   endfunction

   function automatic logic [5:0] model_out(input stim_t s);
      bit stall;
      bit waiting;
      waiting = s.req && !s.ready;
      stall = (s.idex_mr && reads(s, s.idex_rd))
           || (s.br && s.idex_rw && reads(s, s.idex_rd))
           || (s.br && s.exmem_mr && reads(s, s.exmem_rd));
      if (m_err || waiting) return {5'b00001, m_err};
      if (stall)            return {5'b00010, m_err};
      if (s.taken)          return {5'b11100, m_err};
      return {5'b11000, m_err};
   endfunction

   // One clock cycle: drive after the falling edge, check, update model at rising edge.
   task automatic step(input stim_t s, input bit do_rst, input bit use_want,
                       input logic [5:0] want, input string tag);
      logic [5:0] exp;
      @(negedge clk);
      IFID_RS1 = s.rs1; IFID_RS2 = s.rs2; IFID_Branch = s.br; BRANCH_TAKEN = s.taken;
      IDEX_RD = s.idex_rd; IDEX_MemRead = s.idex_mr; IDEX_RegWrite = s.idex_rw;
      EXMEM_RD = s.exmem_rd; EXMEM_MemRead = s.exmem_mr;
      DMEM_REQ = s.req; DMEM_READY = s.ready;
      if (do_rst) begin
         rst_n = 1'b0;
         #1;
         check_eq("reset_outputs", {58'd0, dut_vec()}, {58'd0, 6'b000100});
`ifdef HAZARD_PERF_EN
         check_eq("reset_stall_cnt", {32'd0, STALL_CNT}, 64'd0);
`endif
         m_run = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
         rst_n = 1'b1;
      end
      #1;
      exp = model_out(s);
      check_eq("model", {58'd0, dut_vec()}, {58'd0, exp});
      if (use_want) check_eq(tag, {58'd0, dut_vec()}, {58'd0, want});
      @(posedge clk);
      if (!exp[5]) m_stall++;
      if (exp[3])  m_flush++;
      if (!m_err) begin
         if (s.req && !s.ready) begin
            m_run++;
            if (m_run == TMO) m_err = 1'b1;
         end else begin
            m_run = 0;
         end
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s.rs1 = 5'd1; s.rs2 = 5'd2; s.idex_rd = '0; s.exmem_rd = '0;
      s.br = 0; s.taken = 0; s.idex_mr = 0; s.idex_rw = 0; s.exmem_mr = 0;
      s.req = 0; s.ready = 0;
      return s;
   endfunction

   initial begin
      stim_t s;
      bit    pend;

      s = idle();
      step(s, 1'b1, 1'b1, 6'b110000, "post_reset_idle");

      // load-use on RS2, then same with x0 destination
      s.idex_mr = 1; s.idex_rd = 5'd5; s.rs2 = 5'd5;
      step(s, 0, 1, 6'b000100, "load_use_stall");
      s.idex_rd = 5'd0; s.rs2 = 5'd0;
      step(s, 0, 1, 6'b110000, "load_use_x0");

      // load to x7 feeding a branch on RS1: two stall cycles, then flush
      s = idle(); s.br = 1; s.rs1 = 5'd7; s.idex_mr = 1; s.idex_rw = 1; s.idex_rd = 5'd7;
      step(s, 0, 1, 6'b000100, "load_branch_stall1");
      s.idex_mr = 0; s.idex_rw = 0; s.idex_rd = 0; s.exmem_mr = 1; s.exmem_rd = 5'd7;
      step(s, 0, 1, 6'b000100, "load_branch_stall2");
      s.exmem_mr = 0; s.exmem_rd = 0; s.taken = 1;
      step(s, 0, 1, 6'b111000, "load_branch_flush");
      s = idle();
      step(s, 0, 1, 6'b110000, "after_flush");

      // ALU result feeding a branch: single stall, taken ignored while stalled
      s.br = 1; s.rs2 = 5'd9; s.idex_rw = 1; s.idex_rd = 5'd9; s.taken = 1;
      step(s, 0, 1, 6'b000100, "alu_branch_taken_masked");

      // memory wait 3 cycles with load-use present: hold masks the stall
      s = idle(); s.idex_mr = 1; s.idex_rd = 5'd3; s.rs1 = 5'd3; s.req = 1;
      for (int i = 0; i < 3; i++) step(s, 0, 1, 6'b000010, "mem_wait_hold");
      s.ready = 1;
      step(s, 0, 1, 6'b000100, "mem_ready_release");
      s = idle();
      step(s, 0, 1, 6'b110000, "mem_done_idle");

      // watchdog: 16 hold cycles then sticky timeout, cleared by async reset
      s.req = 1;
      for (int i = 0; i < 16; i++) step(s, 0, 1, 6'b000010, "wdog_hold");
      for (int i = 0; i < 3; i++) step(s, 0, 1, 6'b000011, "wdog_timeout");
      s.ready = 1;
      step(s, 0, 1, 6'b000011, "wdog_sticky");
      s = idle();
      step(s, 1, 1, 6'b110000, "wdog_reset_cleared");

`ifndef HAZARD_PERF_EN
      // request withdrawn mid-wait returns to normal flow
      s.req = 1;
      step(s, 0, 1, 6'b000010, "drop_wait");
      s.req = 0;
      step(s, 0, 1, 6'b110000, "drop_release");
      step(s, 0, 1, 6'b110000, "drop_idle");
`endif

      // randomized traffic; memory requests held until ready
      pend = 0;
      for (int n = 0; n < 1500; n++) begin
         s.rs1 = 5'($urandom_range(0, 3));      s.rs2 = 5'($urandom_range(0, 3));
         s.idex_rd = 5'($urandom_range(0, 3));  s.exmem_rd = 5'($urandom_range(0, 3));
         s.br = 1'($urandom); s.taken = 1'($urandom);
         s.idex_mr = 1'($urandom); s.idex_rw = 1'($urandom); s.exmem_mr = 1'($urandom);
         s.req   = pend ? 1'b1 : ($urandom_range(0, 4) == 0);
         s.ready = s.req ? ($urandom_range(0, 9) < 2) : 1'($urandom);
         step(s, ($urandom_range(0, 99) == 0), 0, 6'b0, "");
         pend = s.req && !s.ready && rst_n;
      end

`ifdef HAZARD_PERF_EN
      check_eq("stall_cnt", {32'd0, STALL_CNT}, 64'(m_stall));
      check_eq("flush_cnt", {32'd0, FLUSH_CNT}, 64'(m_flush));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
